// File: rtl/parity_checker_stream.sv
// parity_checker_stream: one-deep registered stream stage that checks the parity of each beat
//    and keeps error statistics.
//
//    Ports:
//       clk, rst      rising-edge clock, synchronous active-high reset
//       mode          parity mode for the beat being accepted (0 = even, 1 = odd)
//       in_valid/in_ready/in_data/in_parity   upstream handshake, data word and its parity bit
//       out_valid/out_ready/out_data/out_err  downstream handshake, registered data and error flag
//       clr           zeroes err_cnt, beat_cnt and err_sticky (data path untouched)
//       err_cnt       saturating count of accepted beats with a parity error
//       beat_cnt      wrapping count of accepted beats
//       err_sticky    set by any error, held until clr or rst
module parity_checker_stream #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   input  logic              clr,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic              err_sticky
);
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, beat_cnt_q, beat_cnt_d;
   logic              sticky_q, sticky_d;
   logic              accept, e;
   logic [CNT_W-1:0]  err_base, beat_base;
   // The slot frees up in the same cycle it is drained, so full throughput has no bubble.
   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign e        = ^in_data ^ in_parity ^ mode;
   // clr zeroes the counters first; a beat accepted in the same cycle is counted on top.
   assign err_base  = clr ? '0 : err_cnt_q;
   assign beat_base = clr ? '0 : beat_cnt_q;
   always_comb begin
      valid_d    = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
      data_d     = accept ? in_data : data_q;
      err_d      = accept ? e : err_q;
      beat_cnt_d = beat_base + CNT_W'(accept);
      err_cnt_d  = (accept & e & ~&err_base) ? err_base + CNT_W'(1) : err_base;
      sticky_d   = (sticky_q & ~clr) | (accept & e);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         beat_cnt_q <= '0;
         sticky_q   <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         sticky_q   <= sticky_d;
      end
   end
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_err    = err_q;
   assign err_cnt    = err_cnt_q;
   assign beat_cnt   = beat_cnt_q;
   assign err_sticky = sticky_q;
endmodule

// File: tb/tb_parity_checker_stream.sv
// tb_parity_checker_stream: directed table plus hand sequences for parity_checker_stream
module tb_parity_checker_stream;
   logic       clk = 0, rst = 1, mode = 0, in_valid = 0, in_parity = 0, out_ready = 0, clr = 0;
   logic [7:0] in_data = 0;
   logic       rdy8, ov8, oe8, st8, rdy2, ov2, oe2, st2;
   logic [7:0] od8, od2, ec8, bc8;
   logic [1:0] ec2, bc2;
   int         total = 0, bad = 0;
   always #5 clk = ~clk;
   parity_checker_stream #(.DATA_W(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy8),
      .in_data(in_data), .in_parity(in_parity), .out_valid(ov8), .out_ready(out_ready),
      .out_data(od8), .out_err(oe8), .clr(clr), .err_cnt(ec8), .beat_cnt(bc8), .err_sticky(st8));
   parity_checker_stream #(.DATA_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy2),
      .in_data(in_data), .in_parity(in_parity), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_err(oe2), .clr(clr), .err_cnt(ec2), .beat_cnt(bc2), .err_sticky(st2));
   typedef struct {
      logic md, v; logic [7:0] d; logic p, ordy, c;
      logic rdy, ov; logic [7:0] od; logic oe;
      logic [7:0] ec8, bc8; logic [1:0] ec2, bc2; logic st;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t mk(logic md, logic v, logic [7:0] d, logic p, logic ordy, logic c,
                               logic rdy, logic ov, logic [7:0] od, logic oe,
                               logic [7:0] e8, logic [7:0] b8, logic [1:0] e2, logic [1:0] b2, logic st);
      vec_t r;
      r.md = md; r.v = v; r.d = d; r.p = p; r.ordy = ordy; r.c = c;
      r.rdy = rdy; r.ov = ov; r.od = od; r.oe = oe;
      r.ec8 = e8; r.bc8 = b8; r.ec2 = e2; r.bc2 = b2; r.st = st;
      return r;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_all(input string tag, input logic ov, input logic [7:0] od, input logic oe,
                          input logic [7:0] e8, input logic [7:0] b8, input logic [1:0] e2,
                          input logic [1:0] b2, input logic st);
      chk({tag, ".out_valid"}, ov8, ov);
      chk({tag, ".out_data"}, od8, od);
      chk({tag, ".out_err"}, oe8, oe);
      chk({tag, ".err_cnt8"}, ec8, e8);
      chk({tag, ".beat_cnt8"}, bc8, b8);
      chk({tag, ".err_cnt2"}, ec2, e2);
      chk({tag, ".beat_cnt2"}, bc2, b2);
      chk({tag, ".sticky8"}, st8, st);
      chk({tag, ".sticky2"}, st2, st);
      chk({tag, ".out_valid2"}, ov2, ov);
   endtask
   initial begin
      logic [7:0] d;
      logic       p, m;
      // md v  d     p  ordy c  | rdy ov od    oe ec8 bc8 ec2 bc2 st
      tbl.push_back(mk(0, 1, 8'hA5, 0, 1, 0, 1, 1, 8'hA5, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 8'h07, 0, 1, 0, 1, 1, 8'h07, 1, 1, 2, 1, 2, 1));
      tbl.push_back(mk(1, 1, 8'h07, 0, 1, 0, 1, 1, 8'h07, 0, 1, 3, 1, 3, 1));
      tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 1, 1, 8'h00, 1, 2, 4, 2, 0, 1));
      tbl.push_back(mk(0, 0, 8'hFF, 0, 1, 0, 1, 0, 8'h00, 1, 2, 4, 2, 0, 1));
      tbl.push_back(mk(0, 0, 8'hFF, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 1, 1, 8'h11, 0, 0, 1, 0, 1, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 0, 1, 8'h11, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 8'h22, 0, 1, 0, 1, 1, 8'h22, 0, 0, 2, 0, 2, 0));
      tbl.push_back(mk(0, 0, 8'h22, 0, 1, 0, 1, 0, 8'h22, 0, 0, 2, 0, 2, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h22, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 1, 1, 8'h01, 1, 1, 1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 1, 1, 8'h01, 1, 2, 2, 2, 2, 1));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 1, 1, 8'h01, 1, 3, 3, 3, 3, 1));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 1, 1, 8'h01, 1, 4, 4, 3, 0, 1));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 1, 1, 8'h01, 1, 5, 5, 3, 1, 1));
      tbl.push_back(mk(0, 1, 8'h03, 1, 1, 1, 1, 1, 8'h03, 1, 1, 1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 8'h03, 0, 1, 1, 1, 1, 8'h03, 0, 0, 1, 0, 1, 0));
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      rst = 0;
      #1 chk("reset.in_ready", rdy8, 1);
      foreach (tbl[i]) begin
         mode = tbl[i].md; in_valid = tbl[i].v; in_data = tbl[i].d; in_parity = tbl[i].p;
         out_ready = tbl[i].ordy; clr = tbl[i].c;
         #1;
         chk($sformatf("v%0d.in_ready", i), rdy8, tbl[i].rdy);
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", i), tbl[i].ov, tbl[i].od, tbl[i].oe,
                 tbl[i].ec8, tbl[i].bc8, tbl[i].ec2, tbl[i].bc2, tbl[i].st);
      end
      // Reset while a beat is stalled in the output register.
      clr = 0; mode = 0; in_valid = 1; in_data = 8'h5A; in_parity = 1; out_ready = 0;
      @(posedge clk); #1;
      chk("stall.out_valid", ov8, 1);
      chk("stall.in_ready", rdy8, 0);
      rst = 1; in_data = 8'h33; in_parity = 0;
      @(posedge clk); #1;
      rst = 0; in_valid = 0;
      #1;
      chk_all("midrst", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      chk("midrst.in_ready", rdy8, 1);
      @(posedge clk); #1;
      chk("midrst.beat_cnt_after", bc8, 0);
      chk("midrst.out_valid_after", ov8, 0);
      // Back-to-back random beats at full throughput.
      out_ready = 1; in_valid = 1;
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom); p = 1'($urandom); m = 1'($urandom);
         in_data = d; in_parity = p; mode = m;
         #1 chk($sformatf("b2b%0d.in_ready", i), rdy8, 1);
         @(posedge clk); #1;
         chk($sformatf("b2b%0d.out_valid", i), ov8, 1);
         chk($sformatf("b2b%0d.out_data", i), od8, d);
         chk($sformatf("b2b%0d.out_err", i), oe8, ^d ^ p ^ m);
      end
      in_valid = 0;
      chk("b2b.beat_cnt8", bc8, 16);
      chk("b2b.beat_cnt2", bc2, 0);
      @(posedge clk); #1;
      chk("b2b.drained", ov8, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/parity_checker_stream.md
PARITY_CHECKER_STREAM -- requirements
Module: parity_checker_stream

Interface
REQ-001 Parameter DATA_W, default 8, sets the data word width in bits (minimum 1).
REQ-002 Parameter CNT_W, default 8, sets the width of the error and beat counters in bits (minimum 1).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 mode  input  1  parity mode sampled with each accepted beat: 0 = even, 1 = odd.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  received data word.
REQ-009 in_parity  input  1  received parity bit.
REQ-010 out_valid  output  1  checked beat held in the output register.
REQ-011 out_ready  input  1  downstream accepts the output beat.
REQ-012 out_data  output  DATA_W  registered copy of the accepted in_data.
REQ-013 out_err  output  1  parity error flag for the beat in out_data.
REQ-014 clr  input  1  clears the counters and the sticky flag.
REQ-015 err_cnt  output  CNT_W  saturating count of accepted beats with an error.
REQ-016 beat_cnt  output  CNT_W  wrapping count of accepted beats.
REQ-017 err_sticky  output  1  set by any error; held until clr or rst.

Function
REQ-018 A beat is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-019 The output beat is consumed when out_valid and out_ready are both 1 in the same cycle.
REQ-020 in_ready = ~out_valid | out_ready; this is combinational, giving a one-deep pipeline with no bubble at full throughput.
REQ-021 The error term for a beat is e = ^in_data ^ in_parity ^ mode, evaluated at acceptance; e = 1 marks an error.
REQ-022 On acceptance, the next edge loads out_data = in_data and out_err = e, and sets out_valid = 1 (latency 1 cycle).
REQ-023 On consumption without a new acceptance, out_valid clears to 0 and out_data/out_err hold their last values.
REQ-024 On consumption and acceptance in the same cycle, the new beat replaces the old one and out_valid stays 1.
REQ-025 While out_valid = 1 and out_ready = 0, out_data, out_err and out_valid shall hold stable, and in_ready = 0.
REQ-026 beat_cnt increments by 1 per accepted beat and wraps from 2^CNT_W-1 to 0.
REQ-027 err_cnt increments by 1 per accepted beat with e = 1 and saturates at 2^CNT_W-1.
REQ-028 err_sticky sets to 1 on any accepted beat with e = 1.
REQ-029 When clr = 1, the next edge zeroes err_cnt, beat_cnt and err_sticky; a beat accepted in the same cycle is then counted on top, giving beat_cnt = 1, and err_cnt = 1 with err_sticky = 1 if e = 1.
REQ-030 clr does not affect the data path (out_valid, out_data, out_err, in_ready).
REQ-031 Counter and flag updates occur at acceptance, independent of downstream consumption.

Reset
REQ-032 rst = 1 on an edge forces out_valid = 0, out_data = 0, out_err = 0, err_cnt = 0, beat_cnt = 0 and err_sticky = 0.
REQ-033 rst has priority over clr, acceptance and consumption.
REQ-034 A beat held in the output register when reset asserts is discarded, not delivered.
REQ-035 in_ready = 1 in the first cycle after reset deasserts.

Verification (DATA_W=8 unless stated)
REQ-036 Even-mode beats with out_ready = 1:
- mode = 0, in_data = 0xA5, in_parity = 0 -> one cycle later out_valid = 1, out_data = 0xA5, out_err = 0.
- Next beat 0x07 with in_parity = 0 -> out_err = 1, err_cnt = 1, err_sticky = 1, beat_cnt = 2.
REQ-037 Odd mode: mode = 1, in_data = 0x07, in_parity = 0 -> out_err = 0 and err_cnt is unchanged.
- Same mode with in_data = 0x00, in_parity = 0 -> out_err = 1.
REQ-038 Backpressure: hold out_ready = 0 and offer 0x11 then 0x22.
- 0x11 is accepted; in_ready = 0 and out_data = 0x11 stay stable for 5 cycles.
- Raise out_ready -> 0x22 is accepted in the same cycle and out_data = 0x22 on the next cycle.
REQ-039 Saturation and clear (CNT_W = 2):
- 5 error beats -> err_cnt = 3 and beat_cnt = 1.
- clr together with an accepted error beat -> err_cnt = 1, beat_cnt = 1, err_sticky = 1.
REQ-040 Reset mid-stream: rst while out_valid = 1 and out_ready = 0.
- All outputs are 0 the following cycle and in_ready = 1.
- A beat offered in the cycle rst is asserted is not counted.
REQ-041 Back-to-back throughput: 16 random beats with in_valid = 1 and out_ready = 1 -> 16 outputs on 16 consecutive cycles.
- Each out_err equals the reference parity model.
- beat_cnt = 16 mod 2^CNT_W.
